// File: rtl/queue_dispatcher_if.sv
// Bundle of scheduler, queue, downstream and counter signals around the queue dispatcher.
// The master side is the environment (scheduler, FWFT queues, downstream sink, monitor).
// The slave side is the dispatcher itself.
interface queue_dispatcher_if #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_WIDTH       = 64,
  parameter int COUNTER_WIDTH    = 16
);
  localparam int SEL_WIDTH = $clog2(NUMBER_OF_QUEUES);

  // Scheduler selection
  logic                                  sched_valid;
  logic [SEL_WIDTH-1:0]                  sched_selection;

  // FWFT queue heads and pop strobes
  logic [NUMBER_OF_QUEUES-1:0]           q_empty;
  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0] q_head;
  logic [NUMBER_OF_QUEUES-1:0]           q_pop;

  // Downstream valid/ready output
  logic                                  m_valid;
  logic                                  m_ready;
  logic [DATA_WIDTH-1:0]                 m_data;
  logic [SEL_WIDTH-1:0]                  m_queue_id;

  // Measurement counters
  logic [SEL_WIDTH-1:0]                  cnt_sel;
  logic [COUNTER_WIDTH-1:0]              cnt_value;
  logic [COUNTER_WIDTH-1:0]              stale_count;
  logic                                  cnt_clear;

  modport master (
    output sched_valid, sched_selection, q_empty, q_head, m_ready, cnt_sel, cnt_clear,
    input  q_pop, m_valid, m_data, m_queue_id, cnt_value, stale_count
  );

  modport slave (
    input  sched_valid, sched_selection, q_empty, q_head, m_ready, cnt_sel, cnt_clear,
    output q_pop, m_valid, m_data, m_queue_id, cnt_value, stale_count
  );
endinterface

// File: rtl/queue_dispatcher.sv
// Consumer end of the queue-selection path: pops the head of the queue chosen by the
// scheduler and forwards it through a single valid/ready output register.
// Also keeps saturating per-queue grant counters and a stale-selection counter.
module queue_dispatcher #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_WIDTH       = 64,
  parameter int COUNTER_WIDTH    = 16
) (
  input logic              clock,
  input logic              reset,
  queue_dispatcher_if.slave bus
);
  localparam int SEL_WIDTH = $clog2(NUMBER_OF_QUEUES);
  localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = {COUNTER_WIDTH{1'b1}};

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                   state_q;
  logic [DATA_WIDTH-1:0]    m_data_q;
  logic [SEL_WIDTH-1:0]     m_queue_id_q;

  logic [COUNTER_WIDTH-1:0] grant_q [NUMBER_OF_QUEUES];
  logic [COUNTER_WIDTH-1:0] grant_d [NUMBER_OF_QUEUES];
  logic [COUNTER_WIDTH-1:0] stale_q;
  logic [COUNTER_WIDTH-1:0] stale_d;

  logic                     sel_empty;
  logic [DATA_WIDTH-1:0]    sel_head;
  logic                     can_load;
  logic                     take;
  logic                     stale;
  logic [NUMBER_OF_QUEUES-1:0] pop;

  // Select the addressed queue's head and empty flag, then decide pop / stale for this cycle.
  // Reset gates the pop so no queue loses an entry while the dispatcher is being reset.
  always_comb begin
    sel_empty = 1'b1;
    sel_head  = '0;
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      if (bus.sched_selection == SEL_WIDTH'(i)) begin
        sel_empty = bus.q_empty[i];
        sel_head  = bus.q_head[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    can_load = (state_q == EMPTY) || bus.m_ready;
    take     = !reset && bus.sched_valid && !sel_empty && can_load;
    stale    = bus.sched_valid && sel_empty;
    pop      = '0;
    if (take) begin
      pop[bus.sched_selection] = 1'b1;
    end
  end

  // Output register FSM: load on take, drain when the sink accepts without a refill.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= EMPTY;
      m_data_q     <= '0;
      m_queue_id_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (take) begin
            state_q      <= FULL;
            m_data_q     <= sel_head;
            m_queue_id_q <= bus.sched_selection;
          end
        end
        FULL: begin
          if (take) begin
            m_data_q     <= sel_head;
            m_queue_id_q <= bus.sched_selection;
          end else if (bus.m_ready) begin
            state_q <= EMPTY;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

  // Next counter values: clear wins over increment, and every counter sticks at its maximum.
  always_comb begin
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      grant_d[i] = grant_q[i];
      if (bus.cnt_clear) begin
        grant_d[i] = '0;
      end else if (pop[i] && (grant_q[i] != COUNT_MAX)) begin
        grant_d[i] = grant_q[i] + COUNTER_WIDTH'(1);
      end
    end
    stale_d = stale_q;
    if (bus.cnt_clear) begin
      stale_d = '0;
    end else if (stale && (stale_q != COUNT_MAX)) begin
      stale_d = stale_q + COUNTER_WIDTH'(1);
    end
  end

  // Register the grant and stale counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
        grant_q[i] <= '0;
      end
      stale_q <= '0;
    end else begin
      for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
        grant_q[i] <= grant_d[i];
      end
      stale_q <= stale_d;
    end
  end

  assign bus.q_pop       = pop;
  assign bus.m_valid     = (state_q == FULL);
  assign bus.m_data      = m_data_q;
  assign bus.m_queue_id  = m_queue_id_q;
  assign bus.cnt_value   = grant_q[bus.cnt_sel];
  assign bus.stale_count = stale_q;
endmodule

// File: tb/tb_queue_dispatcher.sv
// Directed self-checking bench for queue_dispatcher using 4-bit counters so saturation is reachable.
module tb_queue_dispatcher;
  localparam int NQ = 4;
  localparam int DW = 64;
  localparam int CW = 4;

  logic clock;
  logic reset;
  int   testsRun;
  int   testsFailed;

  queue_dispatcher_if #(.NUMBER_OF_QUEUES(NQ), .DATA_WIDTH(DW), .COUNTER_WIDTH(CW)) bus ();

  queue_dispatcher #(.NUMBER_OF_QUEUES(NQ), .DATA_WIDTH(DW), .COUNTER_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive scheduler, queue-empty and downstream-ready inputs, then let combinational paths settle.
  task automatic applyStimulus(input logic sv, input logic [1:0] sel, input logic [3:0] empty,
                               input logic ready);
    bus.sched_valid     = sv;
    bus.sched_selection = sel;
    bus.q_empty         = empty;
    bus.m_ready         = ready;
    #1;
  endtask

  // Compare one observed value with its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Read a grant counter through the cnt_sel port and check it.
  task automatic checkGrant(input int q, input logic [63:0] expected);
    bus.cnt_sel = 2'(q);
    #1;
    checkOutput($sformatf("grant%0d", q), 64'(bus.cnt_value), expected);
  endtask

  initial begin
    testsRun         = 0;
    testsFailed      = 0;
    reset            = 1'b1;
    bus.sched_valid  = 1'b0;
    bus.sched_selection = '0;
    bus.q_empty      = 4'b1111;
    bus.q_head       = '0;
    bus.m_ready      = 1'b0;
    bus.cnt_sel      = '0;
    bus.cnt_clear    = 1'b0;
    tick();
    tick();

    // No pop may escape while reset is high, even with a valid non-empty selection.
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
    checkOutput("pop_in_reset", 64'(bus.q_pop), 64'h0);
    tick();
    checkOutput("reset_valid", 64'(bus.m_valid), 64'h0);
    checkOutput("reset_data", bus.m_data, 64'h0);
    checkOutput("reset_stale", 64'(bus.stale_count), 64'h0);
    checkGrant(0, 64'h0);

    // Stale selections: every queue empty, scheduler points at queue 2.
    reset = 1'b0;
    applyStimulus(1'b1, 2'd2, 4'b1111, 1'b0);
    checkOutput("stale_pop", 64'(bus.q_pop), 64'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput($sformatf("stale_cnt%0d", i), 64'(bus.stale_count), 64'(i));
      checkOutput("stale_valid", 64'(bus.m_valid), 64'h0);
    end
    applyStimulus(1'b0, 2'd2, 4'b1111, 1'b0);
    bus.cnt_clear = 1'b1;
    tick();
    bus.cnt_clear = 1'b0;
    checkOutput("stale_clear", 64'(bus.stale_count), 64'h0);

    // Single transfer from queue 2.
    bus.q_head[2*DW +: DW] = 64'hA5;
    applyStimulus(1'b1, 2'd2, 4'b1011, 1'b1);
    checkOutput("single_pop", 64'(bus.q_pop), 64'h4);
    tick();
    applyStimulus(1'b0, 2'd2, 4'b1011, 1'b1);
    checkOutput("single_valid", 64'(bus.m_valid), 64'h1);
    checkOutput("single_data", bus.m_data, 64'hA5);
    checkOutput("single_id", 64'(bus.m_queue_id), 64'h2);
    checkOutput("single_pop_off", 64'(bus.q_pop), 64'h0);
    tick();
    checkOutput("single_drain", 64'(bus.m_valid), 64'h0);
    checkOutput("single_hold", bus.m_data, 64'hA5);
    checkGrant(2, 64'h1);

    // Backpressure: fill from queue 3, then stall with queue 1 selected for five cycles.
    bus.q_head = {64'h133, 64'h122, 64'h111, 64'h100};
    applyStimulus(1'b1, 2'd3, 4'b0000, 1'b0);
    checkOutput("bp_fill_pop", 64'(bus.q_pop), 64'h8);
    tick();
    applyStimulus(1'b1, 2'd1, 4'b0000, 1'b0);
    checkOutput("bp_full", 64'(bus.m_valid), 64'h1);
    checkOutput("bp_id", 64'(bus.m_queue_id), 64'h3);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_pop", 64'(bus.q_pop), 64'h0);
      tick();
      checkOutput("bp_data", bus.m_data, 64'h133);
      checkOutput("bp_valid", 64'(bus.m_valid), 64'h1);
    end
    checkOutput("bp_stale", 64'(bus.stale_count), 64'h0);
    applyStimulus(1'b1, 2'd1, 4'b0000, 1'b1);
    checkOutput("bp_release_pop", 64'(bus.q_pop), 64'h2);
    tick();
    checkOutput("bp_reload_valid", 64'(bus.m_valid), 64'h1);
    checkOutput("bp_reload_data", bus.m_data, 64'h111);
    checkOutput("bp_reload_id", 64'(bus.m_queue_id), 64'h1);

    // Drain and clear the counters before streaming.
    applyStimulus(1'b0, 2'd0, 4'b0000, 1'b1);
    bus.cnt_clear = 1'b1;
    tick();
    bus.cnt_clear = 1'b0;
    checkOutput("pre_stream_valid", 64'(bus.m_valid), 64'h0);
    checkGrant(1, 64'h0);

    // Streaming: one selection per cycle across all four queues.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'(i), 4'b0000, 1'b1);
      checkOutput($sformatf("stream_pop%0d", i), 64'(bus.q_pop), 64'(1 << i));
      tick();
      checkOutput($sformatf("stream_valid%0d", i), 64'(bus.m_valid), 64'h1);
      checkOutput($sformatf("stream_id%0d", i), 64'(bus.m_queue_id), 64'(i));
      checkOutput($sformatf("stream_data%0d", i), bus.m_data, 64'h100 + 64'(i * 'h11));
    end
    applyStimulus(1'b0, 2'd0, 4'b0000, 1'b1);
    tick();
    checkOutput("stream_drain", 64'(bus.m_valid), 64'h0);
    for (int i = 0; i < 4; i++) begin
      checkGrant(i, 64'h1);
    end

    // Saturation: twenty more pops from queue 0 on top of its count of one.
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
    repeat (20) tick();
    checkGrant(0, 64'hF);
    bus.cnt_clear = 1'b1;
    #1;
    checkOutput("clear_pop", 64'(bus.q_pop), 64'h1);
    tick();
    bus.cnt_clear = 1'b0;
    #1;
    checkOutput("clear_wins", 64'(bus.cnt_value), 64'h0);

    // Stale selection while stalled still counts.
    applyStimulus(1'b1, 2'd0, 4'b0001, 1'b0);
    checkOutput("stall_stale_pop", 64'(bus.q_pop), 64'h0);
    tick();
    checkOutput("stall_stale_cnt", 64'(bus.stale_count), 64'h1);
    checkOutput("stall_valid", 64'(bus.m_valid), 64'h1);
    checkOutput("stall_data", bus.m_data, 64'h100);

    // Reset in the middle of a stalled transfer.
    applyStimulus(1'b1, 2'd2, 4'b0000, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midreset_pop", 64'(bus.q_pop), 64'h0);
    tick();
    checkOutput("midreset_valid", 64'(bus.m_valid), 64'h0);
    checkOutput("midreset_data", bus.m_data, 64'h0);
    checkOutput("midreset_id", 64'(bus.m_queue_id), 64'h0);
    checkOutput("midreset_stale", 64'(bus.stale_count), 64'h0);
    checkOutput("midreset_pop2", 64'(bus.q_pop), 64'h0);
    for (int i = 0; i < 4; i++) begin
      checkGrant(i, 64'h0);
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/queue_dispatcher.md
Name: queue_dispatcher

Overview:
- Consumer end of the MemorEDF queue-selection path. Takes the scheduler's (valid, selection) pair and pops the head of the chosen FWFT queue. Forwards the popped entry downstream through a single output register with a valid/ready handshake.
- Keeps per-queue saturating grant counters and a stale-selection counter for bandwidth and fairness measurement.

Parameters:
- NUMBER_OF_QUEUES, 4, number of source queues; power of two, >= 2.
- DATA_WIDTH, 64, width of one queue entry.
- COUNTER_WIDTH, 16, width of each grant counter and of the stale counter.

Ports:
- clock  in  1  system clock
- reset  in  1  reset; synchronous, active-high
- sched_valid  in  1  scheduler has a selection
- sched_selection  in  $clog2(NUMBER_OF_QUEUES)  queue chosen by the scheduler
- q_empty  in  NUMBER_OF_QUEUES  per-queue empty flags
- q_head  in  NUMBER_OF_QUEUES*DATA_WIDTH  per-queue FWFT head entries; queue i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- q_pop  out  NUMBER_OF_QUEUES  one-hot pop strobe
- m_valid  out  1  output entry valid
- m_ready  in  1  downstream accepts
- m_data  out  DATA_WIDTH  output entry
- m_queue_id  out  $clog2(NUMBER_OF_QUEUES)  source queue of m_data
- cnt_sel  in  $clog2(NUMBER_OF_QUEUES)  grant counter read index
- cnt_value  out  COUNTER_WIDTH  grant counter of queue cnt_sel; combinational read
- stale_count  out  COUNTER_WIDTH  number of stale selections
- cnt_clear  in  1  clears all counters

Behaviour:
- Output register states: EMPTY (m_valid=0) and FULL (m_valid=1).
- can_load = !m_valid | m_ready.
- take = sched_valid & !q_empty[sched_selection] & can_load.
- stale = sched_valid & q_empty[sched_selection].
- q_pop = take ? (1 << sched_selection) : 0.
  - Combinational; has a path from m_ready.
  - Never more than one bit set.
  - Never asserted for an empty queue.
- On a clock edge with take:
  - m_data <= q_head[sched_selection].
  - m_queue_id <= sched_selection.
  - m_valid <= 1.
  - Latency: pop cycle to m_valid is 1 cycle.
- Edge with m_valid & m_ready & !take: m_valid <= 0. m_data and m_queue_id hold their old values.
- Edge with m_valid & m_ready & take: back-to-back transfer; m_valid stays 1 with the new entry. Sustained throughput is 1 entry/cycle.
- m_valid & !m_ready: output is stalled.
  - m_data and m_queue_id are held stable.
  - q_pop = 0.
  - A valid selection is ignored and is not counted as stale unless the stale condition holds.
- sched_valid=0: no pop, no counter change.
- Stale selection (scheduler points at an empty queue): no pop, no load, stale_count increments.
  - The stale count is independent of can_load.
  - Output state is unchanged apart from any drain in the same cycle.
- Grant counter of queue i increments on every edge where q_pop[i]=1.
- All counters saturate at 2^COUNTER_WIDTH-1 and never wrap.
- cnt_clear: all counters go to 0 on the next edge. It has priority over a same-cycle increment, so the lost increment is not applied.
- cnt_clear does not affect m_valid, m_data or the pop logic.
- Reset, also mid-transfer:
  - m_valid=0, m_data=0, m_queue_id=0, all counters=0.
  - q_pop is 0 while reset is high.
  - An in-flight output entry is dropped; the downstream must also be reset.
- cnt_value is a combinational read of the counter indexed by cnt_sel.
- m_queue_id and the counters use sched_selection directly. No modulo or range check is needed because NUMBER_OF_QUEUES is a power of two.

Test Plan:
- Reset, then all q_empty=1 and sched_valid=1, sched_selection=2:
  - q_pop=0000, m_valid=0.
  - stale_count increments once per cycle: 3 after 3 cycles.
- Single transfer:
  - Stimulus: q_empty=1011, q_head[2]=0xA5, sched_selection=2, sched_valid=1 for 1 cycle, m_ready=1.
  - Response: q_pop=0100 for exactly that cycle; next cycle m_valid=1, m_data=0xA5, m_queue_id=2; following cycle m_valid=0; cnt_sel=2 gives cnt_value=1.
- Backpressure:
  - Stimulus: output FULL with m_ready=0 for 5 cycles, sched_valid=1 on non-empty queue 1.
  - Response: q_pop=0 throughout; m_data stable; stale_count unchanged. When m_ready=1: pop and reload in the same cycle with no bubble.
- Streaming:
  - Stimulus: m_ready=1, selections 0,1,2,3 on consecutive cycles, all non-empty.
  - Response: 4 consecutive m_valid beats with m_queue_id 0,1,2,3; each grant counter = 1.
- Saturation and clear:
  - Stimulus: COUNTER_WIDTH=4, 20 pops from queue 0.
  - Response: cnt_value=15. Then cnt_clear for 1 cycle during a pop: cnt_value=0 the next cycle.
- Reset mid-operation:
  - Stimulus: assert reset while m_valid=1 and m_ready=0.
  - Response: next cycle m_valid=0, all counters 0, q_pop=0 during reset.
